// File: rtl/hyperbus_tf_splitter.sv
// Purpose: splits one upstream HyperBus transaction into PHY chunks of at most t_burst_max words and re-marks read lasts.
// Latency: first chunk 1 cycle after accept, then 1 chunk/cycle; tf_ready_o returns 1 cycle after the final read last.
// Backpressure: valid/ready; tf_o/tf_valid_o held while tf_ready_i=0; rx path is a combinational passthrough.

package hyperbus_tf_pkg;

  typedef struct packed {
    logic [3:0]  t_latency_access;
    logic [3:0]  t_latency_additional;
    logic [15:0] t_cs_max;
    logic [3:0]  t_read_write_recovery;
    logic [3:0]  t_rx_clk_delay;
    logic [15:0] t_burst_max;
  } hyper_cfg_t;

  typedef struct packed {
    logic        write;
    logic        address_space;
    logic        burst_type;
    logic [31:0] address;
    logic [14:0] burst;
  } hyper_tf_t;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        error;
  } phy_rx_t;

endpackage

module hyperbus_tf_splitter
  import hyperbus_tf_pkg::*;
#(
  parameter int unsigned BurstCntWidth = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  hyper_cfg_t cfg_i,
  input  hyper_tf_t  tf_i,
  input  logic       tf_valid_i,
  output logic       tf_ready_o,
  output hyper_tf_t  tf_o,
  output logic       tf_valid_o,
  input  logic       tf_ready_i,
  input  phy_rx_t    rx_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output phy_rx_t    rx_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    Idle   = 2'd0,
    Issue  = 2'd1,
    WaitRx = 2'd2
  } state_e;

  state_e                   state_q;
  hyper_tf_t                tf_q;        // chunk currently presented to the PHY
  logic                     tf_valid_q;
  logic [15:0]              max_q;
  logic                     no_split_q;
  logic [14:0]              remaining_q; // words left, including the presented chunk
  logic [BurstCntWidth-1:0] pending_q;   // read chunks issued whose last has not returned
  logic                     issue_done_q;

  logic        tf_hs;
  logic        rx_last_hs;
  logic        final_last;
  logic        last_chunk;
  logic        no_split_in;
  logic [14:0] rem_nxt;
  logic [31:0] addr_nxt;

  // Chunk length: a no-split transaction goes out whole; otherwise clip to max.
  function automatic logic [14:0] chunk_len(input logic [14:0] rem, input logic [15:0] mx,
                                            input logic ns);
    if (ns || ({1'b0, rem} <= mx)) return rem;
    else return mx[14:0];
  endfunction

  assign tf_hs       = tf_valid_q & tf_ready_i;
  assign rx_last_hs  = rx_valid_i & rx_ready_i & rx_i.last;
  assign final_last  = rx_last_hs & issue_done_q & (pending_q == BurstCntWidth'(1));
  assign rem_nxt     = remaining_q - tf_q.burst;
  assign addr_nxt    = tf_q.address + {16'b0, tf_q.burst, 1'b0};
  assign last_chunk  = (rem_nxt == 15'd0);
  assign no_split_in = (cfg_i.t_burst_max == 16'd0) | ~tf_i.burst_type |
                       tf_i.address_space | (tf_i.burst == 15'd0);

  assign tf_ready_o = (state_q == Idle);
  assign tf_valid_o = tf_valid_q;
  assign tf_o       = tf_q;
  assign busy_o     = (state_q != Idle);
  assign rx_ready_o = rx_ready_i;
  assign rx_valid_o = rx_valid_i;

  // Forward read beats; only the last of the final outstanding chunk keeps its last flag.
  always_comb begin
    rx_o = rx_i;
    if (state_q != Idle) begin
      rx_o.last = rx_i.last & issue_done_q & (pending_q == BurstCntWidth'(1));
    end
  end

  // Transaction FSM: latch upstream, issue chunks back to back, wait for the final read last.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= Idle;
      tf_q         <= '0;
      tf_valid_q   <= 1'b0;
      max_q        <= '0;
      no_split_q   <= 1'b0;
      remaining_q  <= '0;
      issue_done_q <= 1'b0;
    end else begin
      case (state_q)
        Idle: begin
          if (tf_valid_i) begin
            tf_q         <= tf_i;
            tf_q.burst   <= chunk_len(tf_i.burst, cfg_i.t_burst_max, no_split_in);
            remaining_q  <= tf_i.burst;
            max_q        <= cfg_i.t_burst_max;
            no_split_q   <= no_split_in;
            tf_valid_q   <= 1'b1;
            issue_done_q <= 1'b0;
            state_q      <= Issue;
          end
        end
        Issue: begin
          if (tf_hs) begin
            if (last_chunk) begin
              tf_valid_q   <= 1'b0;
              issue_done_q <= 1'b1;
              state_q      <= tf_q.write ? Idle : WaitRx;
            end else begin
              tf_q.address <= addr_nxt;
              tf_q.burst   <= chunk_len(rem_nxt, max_q, no_split_q);
              remaining_q  <= rem_nxt;
            end
          end
        end
        WaitRx: begin
          if (final_last) begin
            issue_done_q <= 1'b0;
            state_q      <= Idle;
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

  // Outstanding read chunk count: +1 per read chunk issued, -1 per returned last, floored at 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      case ({tf_hs & ~tf_q.write, rx_last_hs & (pending_q != '0)})
        2'b10:   pending_q <= pending_q + BurstCntWidth'(1);
        2'b01:   pending_q <= pending_q - BurstCntWidth'(1);
        default: pending_q <= pending_q;
      endcase
    end
  end

  logic unused_cfg;
  assign unused_cfg = ^{cfg_i.t_latency_access, cfg_i.t_latency_additional, cfg_i.t_cs_max,
                        cfg_i.t_read_write_recovery, cfg_i.t_rx_clk_delay};

endmodule

// File: tb/tb_hyperbus_tf_splitter.sv
// Purpose: randomized bench for hyperbus_tf_splitter against a chunk-list reference model and PHY model.
// Latency: expects first chunk 1 cycle after accept, 1 chunk/cycle under constant ready, Idle 1 cycle after completion.
// Backpressure: drives random/patterned tf_ready_i and rx valid/ready; checks held chunks while stalled.
module tb_hyperbus_tf_splitter;
  import hyperbus_tf_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  hyper_cfg_t cfg_i;
  hyper_tf_t  tf_i;
  logic       tf_valid_i;
  logic       tf_ready_o;
  hyper_tf_t  tf_o;
  logic       tf_valid_o;
  logic       tf_ready_i;
  phy_rx_t    rx_i;
  logic       rx_valid_i;
  logic       rx_ready_o;
  phy_rx_t    rx_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       busy_o;

  hyperbus_tf_splitter #(.BurstCntWidth(16)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cfg_i      (cfg_i),
    .tf_i       (tf_i),
    .tf_valid_i (tf_valid_i),
    .tf_ready_o (tf_ready_o),
    .tf_o       (tf_o),
    .tf_valid_o (tf_valid_o),
    .tf_ready_i (tf_ready_i),
    .rx_i       (rx_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .rx_o       (rx_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  hyper_tf_t exp_q[$];     // expected chunks, in issue order
  phy_rx_t   src_q[$];     // beats the PHY model still has to return
  bit        lastexp_q[$]; // expected rx_o.last for each queued beat

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: the list of chunks one transaction should produce.
  task automatic plan(input hyper_tf_t t, input int mx);
    hyper_tf_t   c;
    int          rem;
    int          l;
    logic [31:0] a;
    exp_q.delete();
    if (mx == 0 || t.burst_type == 1'b0 || t.address_space == 1'b1 || t.burst == 15'd0) begin
      exp_q.push_back(t);
    end else begin
      rem = int'(t.burst);
      a   = t.address;
      while (rem > 0) begin
        l         = (rem < mx) ? rem : mx;
        c         = t;
        c.address = a;
        c.burst   = 15'(l);
        exp_q.push_back(c);
        rem -= l;
        a    = a + 32'(2 * l);
      end
    end
  endtask

  // PHY model: a read chunk comes back as 1..3 beats, the last one flagged.
  task automatic phy_return(input bit final_chunk);
    phy_rx_t b;
    int      nb;
    nb = $urandom_range(1, 3);
    for (int k = 0; k < nb; k++) begin
      b.data  = 16'($urandom);
      b.error = 1'($urandom_range(0, 1));
      b.last  = (k == nb - 1);
      src_q.push_back(b);
      lastexp_q.push_back((k == nb - 1) && final_chunk);
    end
  endtask

  // One full transaction. rmode: 0 = ready always 1, 1 = random ready, 2 = 1-0-0-1 stall pattern.
  task automatic run_tf(input hyper_tf_t t, input int mx, input int rmode);
    hyper_cfg_t cfg;
    hyper_tf_t  e;
    hyper_tf_t  prev;
    phy_rx_t    beat;
    bit         stalled;
    bit         done;
    bit         el;
    int         cyc;
    plan(t, mx);
    src_q.delete();
    lastexp_q.delete();
    cfg             = hyper_cfg_t'({$urandom, $urandom});
    cfg.t_burst_max = 16'(mx);
    @(posedge clk_i); #1;
    tf_i       = t;
    tf_valid_i = 1'b1;
    cfg_i      = cfg;
    tf_ready_i = 1'b0;
    rx_valid_i = 1'b0;
    @(negedge clk_i);
    check("idle_ready", 64'(tf_ready_o), 64'(1));
    check("idle_busy", 64'(busy_o), 64'(0));
    @(posedge clk_i); #1;
    tf_valid_i        = 1'b0;
    tf_i              = hyper_tf_t'({$urandom, $urandom});
    cfg_i.t_burst_max = 16'($urandom_range(1, 8));
    stalled = 1'b0;
    done    = 1'b0;
    prev    = '0;
    cyc     = 0;
    while (!done && cyc < 3000) begin
      case (rmode)
        0:       tf_ready_i = 1'b1;
        1:       tf_ready_i = 1'($urandom_range(0, 1));
        default: tf_ready_i = (cyc == 1 || cyc == 2) ? 1'b0 : 1'b1;
      endcase
      if (src_q.size() > 0) begin
        rx_i       = src_q[0];
        rx_valid_i = ($urandom_range(0, 3) != 0);
      end else begin
        rx_i       = phy_rx_t'($urandom);
        rx_valid_i = 1'b0;
      end
      rx_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk_i);
      if (cyc == 0) check("first_latency", 64'(tf_valid_o), 64'(1));
      if (stalled && tf_valid_o) check("hold_while_stalled", 64'(tf_o), 64'(prev));
      if (rmode == 0 && exp_q.size() > 0) check("back_to_back", 64'(tf_valid_o), 64'(1));
      check("rx_ready_pass", 64'(rx_ready_o), 64'(rx_ready_i));
      if (tf_valid_o && tf_ready_i) begin
        if (exp_q.size() == 0) begin
          check("extra_chunk", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("chunk", 64'(tf_o), 64'(e));
          if (!t.write) phy_return(exp_q.size() == 0);
        end
      end
      stalled = tf_valid_o & ~tf_ready_i;
      prev    = tf_o;
      if (rx_valid_i && rx_ready_i) begin
        beat = src_q.pop_front();
        el   = lastexp_q.pop_front();
        check("rx_valid_pass", 64'(rx_valid_o), 64'(1));
        check("rx_data", 64'({rx_o.data, rx_o.error}), 64'({beat.data, beat.error}));
        check("rx_last_mark", 64'(rx_o.last), 64'(el));
        if (el) check("busy_at_final_last", 64'({busy_o, tf_ready_o}), 64'(2'b10));
      end
      done = (exp_q.size() == 0) && (src_q.size() == 0);
      @(posedge clk_i); #1;
      cyc++;
    end
    if (!done) check("timeout", 64'(0), 64'(1));
    tf_ready_i = 1'b0;
    rx_valid_i = 1'b0;
    @(negedge clk_i);
    check("end_ready", 64'(tf_ready_o), 64'(1));
    check("end_busy", 64'(busy_o), 64'(0));
    check("end_valid", 64'(tf_valid_o), 64'(0));
  endtask

  function automatic hyper_tf_t mk(input bit wr, input bit as, input bit bt,
                                   input logic [31:0] addr, input int burst);
    hyper_tf_t t;
    t.write         = wr;
    t.address_space = as;
    t.burst_type    = bt;
    t.address       = addr;
    t.burst         = 15'(burst);
    return t;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hyper_tf_t t;
    rst_ni     = 1'b0;
    cfg_i      = '0;
    tf_i       = '0;
    tf_valid_i = 1'b0;
    tf_ready_i = 1'b0;
    rx_i       = '0;
    rx_valid_i = 1'b0;
    rx_ready_i = 1'b0;
    #12;
    check("rst_valid", 64'(tf_valid_o), 64'(0));
    check("rst_tf", 64'(tf_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_ready", 64'(tf_ready_o), 64'(1));
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Directed scenarios
    run_tf(mk(1'b0, 1'b0, 1'b1, 32'h0000_1000, 100), 32, 0);
    run_tf(mk(1'b1, 1'b0, 1'b1, 32'h0000_0000, 64), 32, 0);
    run_tf(mk(1'b0, 1'b0, 1'b0, 32'h0000_2000, 100), 32, 0);
    run_tf(mk(1'b0, 1'b0, 1'b1, 32'h0000_3000, 100), 0, 1);
    run_tf(mk(1'b1, 1'b1, 1'b1, 32'h0000_0004, 100), 32, 1);
    run_tf(mk(1'b0, 1'b0, 1'b1, 32'h0000_0010, 0), 32, 1);
    run_tf(mk(1'b1, 1'b0, 1'b1, 32'h0000_4000, 96), 32, 2);
    run_tf(mk(1'b1, 1'b0, 1'b1, 32'hFFFF_FFC0, 64), 32, 0);

    // Reset during the 2nd chunk of a read
    @(posedge clk_i); #1;
    tf_i              = mk(1'b0, 1'b0, 1'b1, 32'h0000_5000, 100);
    cfg_i.t_burst_max = 16'd32;
    tf_valid_i        = 1'b1;
    @(posedge clk_i); #1;
    tf_valid_i = 1'b0;
    tf_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("second_chunk_addr", 64'(tf_o.address), 64'(32'h0000_5040));
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_valid", 64'(tf_valid_o), 64'(0));
    check("arst_busy", 64'(busy_o), 64'(0));
    check("arst_ready", 64'(tf_ready_o), 64'(1));
    tf_ready_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    // A stray last while Idle is forwarded unmasked
    rx_i       = '{data: 16'hBEEF, last: 1'b1, error: 1'b0};
    rx_valid_i = 1'b1;
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    check("idle_rx_last", 64'({rx_valid_o, rx_o}), 64'({1'b1, 16'hBEEF, 1'b1, 1'b0}));
    @(posedge clk_i); #1;
    rx_valid_i = 1'b0;
    run_tf(mk(1'b0, 1'b0, 1'b1, 32'h0000_6000, 70), 16, 1);

    // Random transactions
    for (int n = 0; n < 30; n++) begin
      t = mk(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) != 0),
             $urandom, $urandom_range(0, 200));
      run_tf(t, $urandom_range(0, 40), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hyperbus_tf_splitter.md
Name: hyperbus_tf_splitter

Overview:
- Sits between the AXI-side transaction generator and the HyperBus PHY.
- Breaks one upstream hyper_tf_t into PHY transfers of at most cfg_i.t_burst_max 16-bit words, so that CS# low time meets the device tCSM limit.
- Re-marks the read return stream so that downstream sees exactly one rx last per original transaction.

Parameters:
- BurstCntWidth, 16, width of the internal chunk counters (covers 2^15 chunks).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cfg_i  in  hyper_cfg_t (48)  configuration; only t_burst_max is used
- tf_i  in  hyper_tf_t (50)  upstream transaction
- tf_valid_i  in  1  upstream valid
- tf_ready_o  out  1  upstream ready
- tf_o  out  hyper_tf_t (50)  chunk to PHY
- tf_valid_o  out  1  chunk valid
- tf_ready_i  in  1  PHY ready
- rx_i  in  phy_rx_t (18)  read beat from PHY
- rx_valid_i  in  1  PHY rx valid
- rx_ready_o  out  1  rx ready toward PHY
- rx_o  out  phy_rx_t (18)  re-marked read beat
- rx_valid_o  out  1  rx valid downstream
- rx_ready_i  in  1  downstream rx ready
- busy_o  out  1  transaction in flight (state != Idle)

Behaviour:
- Clock is clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: state=Idle, tf_valid_o=0, tf_o=0, pending=0, issue_done=0.
- tf_ready_o = (state==Idle). rx_ready_o, rx_valid_o and rx_o are combinational passthrough.
- States:
  - Idle: on tf_valid_i & tf_ready_o, latch tf_i and max=cfg_i.t_burst_max, then go to Issue. cfg_i is sampled only here.
  - Issue: tf_valid_o=1. tf_o equals the latched transaction except that burst=len and address=cur_addr.
  - WaitRx: reads only. Waits for the final rx last.
- Chunk length: len = min(remaining, max).
- No split: the original transaction is issued as a single chunk when any of the following holds:
  - max==0
  - burst_type==0 (wrapped)
  - address_space==1 (register access)
  - burst==0 (forwarded unchanged)
- On each tf_valid_o & tf_ready_i handshake:
  - remaining -= len
  - cur_addr += 2*len (byte address, 32-bit, wraps modulo 2^32)
  - pending += 1 if read
  - the next chunk is registered on the same edge, so back-to-back chunks go out at 1 chunk/cycle under constant ready.
- When remaining reaches 0 on a handshake:
  - set issue_done=1 and deassert tf_valid_o next cycle.
  - write: go to Idle.
  - read: go to WaitRx, unless the final last has already completed.
- tf_o and tf_valid_o are held stable while tf_ready_i=0 (no retraction, no change).
- Rx re-marking:
  - rx_o.data and rx_o.error pass through.
  - rx_o.last = rx_i.last & issue_done & (pending==1).
  - On rx_valid_i & rx_ready_i & rx_i.last: pending -= 1.
  - If this is the final last, clear issue_done and go to Idle next cycle.
- Simultaneous issue handshake and rx last in the same cycle: pending is unchanged (+1-1). issue_done takes effect for last-marking from the next cycle.
- An rx beat arriving in Idle passes through unmodified, with last unmasked.
- Latency: the first chunk is presented 1 cycle after upstream accept. After the final read last, tf_ready_o returns 1 cycle later.
- Reset mid-operation returns to Idle immediately. In-flight chunk state is discarded. The PHY must be reset together with this block.
- Chunk counter: pending is BurstCntWidth bits and never underflows; a last with pending==0 leaves it at 0.

Test Plan:
- Linear read, addr 0x1000, burst 100, max 32, ready=1 -> chunks (0x1000,32), (0x1040,32), (0x1080,32), (0x10C0,4) on 4 consecutive cycles. PHY returns 4 lasts; only the 4th is forwarded as rx_o.last. tf_ready_o=1 the cycle after it.
- Exact multiple: write, burst 64, max 32, addr 0x0 -> chunks (0x0,32), (0x40,32). Idle the cycle after the 2nd handshake; busy_o=0.
- Wrapped read (burst_type=0), burst 100, max 32 -> one chunk, burst 100, address unchanged. The single rx last is forwarded.
- max=0 and register access (address_space=1) -> one unmodified chunk each. cfg_i changed mid-transaction -> chunking unaffected.
- Backpressure: tf_ready_i toggling 1-0-0-1 during a 3-chunk write -> tf_o stable while stalled, no chunk lost or duplicated. addr 0xFFFFFFC0, burst 64, max 32 -> 2nd chunk at 0x00000000.
- rst_ni pulsed low during the 2nd chunk of a read -> tf_valid_o=0 and busy_o=0 asynchronously, tf_ready_o=1. A fresh transaction then splits correctly.
